// File: rtl/star_route_unit.sv
// star_route_unit: registered route-compute and flit-forwarding stage for the
// star NoC. Leaf mode picks local/uplink, hub mode picks the leaf port from the
// destination cluster. The route is locked on the head flit until the tail.
//
// state | meaning
// IDLE  | waiting for a head flit
// FWD   | route locked, forwarding body/tail flits
// DROP  | unroutable packet, discarding until tail
module star_route_unit #(
   parameter int MODE      = 0,
   parameter int ADDR_W    = 4,
   parameter int LOCAL_W   = 2,
   parameter int NUM_PORTS = 5,
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic                         in_head_i,
   input  logic                         in_tail_i,
   input  logic [ADDR_W-1:0]            in_src_i,
   input  logic [ADDR_W-1:0]            in_dest_i,
   input  logic [DATA_W-1:0]            in_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [NUM_PORTS-1:0]         out_port_o,
   output logic [$clog2(NUM_PORTS)-1:0] out_port_idx_o,
   output logic                         out_head_o,
   output logic                         out_tail_o,
   output logic [DATA_W-1:0]            out_data_o,
   output logic                         err_drop_o,
   output logic                         err_proto_o,
   output logic [CNT_W-1:0]             pkt_count_o
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FWD  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   route_q, route_d;
   logic               out_valid_q;
   logic [NUM_PORTS-1:0] out_port_q;
   logic [IDX_W-1:0]   out_idx_q;
   logic               out_head_q, out_tail_q;
   logic [DATA_W-1:0]  out_data_q;
   logic               err_drop_q, err_drop_d;
   logic               err_proto_q, err_proto_d;
   logic [CNT_W-1:0]   cnt_q;

   logic               head_ok;
   logic [IDX_W-1:0]   head_idx;
   logic               accept, consume, fwd;
   logic [IDX_W-1:0]   fwd_idx;

   // Route function applied to the current head flit.
   if (MODE == 0) begin : g_leaf
      assign head_ok  = 1'b1;
      assign head_idx = (in_dest_i == in_src_i) ? '0 : IDX_W'(1);
   end else begin : g_hub
      logic [ADDR_W-1:0] cluster;
      logic              unused_src;
      assign cluster    = in_dest_i >> LOCAL_W;
      assign head_ok    = 32'(cluster) < NUM_PORTS;
      assign head_idx   = cluster[IDX_W-1:0];
      // The hub routes on destination only; the source address is not needed.
      assign unused_src = ^in_src_i;
   end

   // DROP swallows flits regardless of the output stage.
   assign in_ready_o = (state_q == S_DROP) | ~out_valid_q | out_ready_i;
   assign accept     = in_valid_i & in_ready_o;
   assign consume    = out_valid_q & out_ready_i;

   // Packet framing: decide whether the accepted flit is forwarded, dropped or flagged.
   always_comb begin
      state_d     = state_q;
      route_d     = route_q;
      fwd         = 1'b0;
      fwd_idx     = route_q;
      err_drop_d  = 1'b0;
      err_proto_d = 1'b0;
      if (accept) begin
         case (state_q)
            S_IDLE: begin
               if (!in_head_i) begin
                  err_proto_d = 1'b1;
               end else if (head_ok) begin
                  fwd     = 1'b1;
                  fwd_idx = head_idx;
                  route_d = head_idx;
                  state_d = in_tail_i ? S_IDLE : S_FWD;
               end else begin
                  err_drop_d = 1'b1;
                  state_d    = in_tail_i ? S_IDLE : S_DROP;
               end
            end
            S_FWD: begin
               fwd = 1'b1;
               if (in_tail_i) state_d = S_IDLE;
            end
            S_DROP: begin
               if (in_tail_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM, locked route and error pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         route_q     <= '0;
         err_drop_q  <= 1'b0;
         err_proto_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         route_q     <= route_d;
         err_drop_q  <= err_drop_d;
         err_proto_q <= err_proto_d;
      end
   end

   // Output register stage; holds its contents while stalled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         out_port_q  <= '0;
         out_idx_q   <= '0;
         out_head_q  <= 1'b0;
         out_tail_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (fwd) begin
         out_valid_q <= 1'b1;
         out_port_q  <= NUM_PORTS'(1) << fwd_idx;
         out_idx_q   <= fwd_idx;
         out_head_q  <= in_head_i;
         out_tail_q  <= in_tail_i;
         out_data_q  <= in_data_i;
      end else if (consume) begin
         out_valid_q <= 1'b0;
      end
   end

   // Count packets as their tail leaves downstream.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (consume && out_tail_q) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_valid_o    = out_valid_q;
   assign out_port_o     = out_port_q;
   assign out_port_idx_o = out_idx_q;
   assign out_head_o     = out_head_q;
   assign out_tail_o     = out_tail_q;
   assign out_data_o     = out_data_q;
   assign err_drop_o     = err_drop_q;
   assign err_proto_o    = err_proto_q;
   assign pkt_count_o    = cnt_q;

endmodule

// File: tb/tb_star_route_unit.sv
// Bench for star_route_unit: a leaf instance (4 ports) and a hub instance
// (3 ports, 4-bit counter) run side by side against a packet-level model.
module tb_star_route_unit;

   typedef struct {
      bit          head;
      bit          tail;
      logic [3:0]  src;
      logic [3:0]  dest;
      logic [15:0] data;
   } flit_t;

   typedef struct {
      int          idx;
      int          port;
      logic [15:0] data;
   } log_t;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid [2];
   logic        in_ready [2];
   logic        in_head  [2];
   logic        in_tail  [2];
   logic [3:0]  in_src   [2];
   logic [3:0]  in_dest  [2];
   logic [15:0] in_data  [2];
   logic        out_valid[2];
   logic        out_ready[2];
   logic [1:0]  out_idx  [2];
   logic        out_head [2];
   logic        out_tail [2];
   logic [15:0] out_data [2];
   logic        err_drop [2];
   logic        err_proto[2];
   logic [3:0]  out_port_l;
   logic [2:0]  out_port_h;
   logic [15:0] cnt_l;
   logic [3:0]  cnt_h;

   star_route_unit #(.MODE(0), .ADDR_W(4), .LOCAL_W(2), .NUM_PORTS(4), .DATA_W(16), .CNT_W(16)) u_leaf (
      .clk_i(clk), .rst_ni(rst_ni),
      .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_head_i(in_head[0]), .in_tail_i(in_tail[0]),
      .in_src_i(in_src[0]), .in_dest_i(in_dest[0]), .in_data_i(in_data[0]),
      .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_port_o(out_port_l),
      .out_port_idx_o(out_idx[0]), .out_head_o(out_head[0]), .out_tail_o(out_tail[0]),
      .out_data_o(out_data[0]), .err_drop_o(err_drop[0]), .err_proto_o(err_proto[0]),
      .pkt_count_o(cnt_l));

   star_route_unit #(.MODE(1), .ADDR_W(4), .LOCAL_W(2), .NUM_PORTS(3), .DATA_W(16), .CNT_W(4)) u_hub (
      .clk_i(clk), .rst_ni(rst_ni),
      .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_head_i(in_head[1]), .in_tail_i(in_tail[1]),
      .in_src_i(in_src[1]), .in_dest_i(in_dest[1]), .in_data_i(in_data[1]),
      .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_port_o(out_port_h),
      .out_port_idx_o(out_idx[1]), .out_head_o(out_head[1]), .out_tail_o(out_tail[1]),
      .out_data_o(out_data[1]), .err_drop_o(err_drop[1]), .err_proto_o(err_proto[1]),
      .pkt_count_o(cnt_h));

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   flit_t sq[2][$];
   log_t  lg[2][$];
   int    drops_seen [2];
   int    protos_seen[2];
   int    vrate = 100;
   int    rdy_force[2];

   // model: packet mode 0 idle / 1 forwarding / 2 discarding, plus output slot
   int          ms[2], mroute[2], midx[2], mcnt[2];
   bit          mv[2], mh[2], mt[2], med[2], mep[2];
   logic [15:0] md[2];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int route(int k, logic [3:0] s, logic [3:0] d);
      int c;
      if (k == 0) return (d == s) ? 0 : 1;
      c = int'(d) / 4;
      return (c < 3) ? c : -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         ms[k] = 0; mroute[k] = 0; midx[k] = 0; mcnt[k] = 0;
         mv[k] = 0; mh[k] = 0; mt[k] = 0; med[k] = 0; mep[k] = 0; md[k] = '0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit ird, acc, cons, ld;
         int lidx, r;
         flit_t f;
         ird  = (ms[k] == 2) || !mv[k] || out_ready[k];
         acc  = in_valid[k] && ird;
         cons = mv[k] && out_ready[k];
         med[k] = 0; mep[k] = 0; ld = 0; lidx = 0;
         if (cons && mt[k]) mcnt[k]++;
         if (acc) begin
            f = sq[k].pop_front();
            if (ms[k] == 0) begin
               if (!f.head) mep[k] = 1;
               else begin
                  r = route(k, f.src, f.dest);
                  if (r >= 0) begin
                     ld = 1; lidx = r; mroute[k] = r;
                     ms[k] = f.tail ? 0 : 1;
                  end else begin
                     med[k] = 1;
                     ms[k] = f.tail ? 0 : 2;
                  end
               end
            end else if (ms[k] == 1) begin
               ld = 1; lidx = mroute[k];
               if (f.tail) ms[k] = 0;
            end else if (f.tail) ms[k] = 0;
         end
         if (ld) begin
            mv[k] = 1; mh[k] = f.head; mt[k] = f.tail; md[k] = f.data; midx[k] = lidx;
         end else if (cons) mv[k] = 0;
      end
   endtask

   task automatic drive();
      for (int k = 0; k < 2; k++) begin
         if (sq[k].size() > 0 && $urandom_range(99) < vrate) begin
            in_valid[k] = 1'b1;
            in_head[k]  = sq[k][0].head;
            in_tail[k]  = sq[k][0].tail;
            in_src[k]   = sq[k][0].src;
            in_dest[k]  = sq[k][0].dest;
            in_data[k]  = sq[k][0].data;
         end else begin
            in_valid[k] = 1'b0;
            in_head[k]  = 1'($urandom);
            in_tail[k]  = 1'($urandom);
            in_src[k]   = 4'($urandom);
            in_dest[k]  = 4'($urandom);
            in_data[k]  = 16'($urandom);
         end
         if (rdy_force[k] == 1) out_ready[k] = 1'b1;
         else if (rdy_force[k] == 0) out_ready[k] = 1'b0;
         else out_ready[k] = ($urandom_range(99) < 70);
      end
   endtask

   task automatic run_cycles(int n);
      repeat (n) begin
         @(posedge clk);
         if (rst_ni) model_step();
         #2;
         drive();
      end
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      chk("rst_async_valid_leaf", 32'(out_valid[0]), 0);
      chk("rst_async_valid_hub", 32'(out_valid[1]), 0);
      chk("rst_async_port_leaf", 32'(out_port_l), 0);
      model_reset();
      for (int k = 0; k < 2; k++) in_valid[k] = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_ni = 1'b1;
      chk_en = 1;
   endtask

   task automatic wait_drain(int budget);
      int c = 0;
      while ((sq[0].size() > 0 || sq[1].size() > 0 || mv[0] || mv[1]) && c < budget) begin
         run_cycles(1);
         c++;
      end
      run_cycles(2);
      checks++;
      if (c >= budget) begin
         errors++;
         $display("FAIL drain_timeout: got %0d cycles required below %0d", c, budget);
      end
   endtask

   task automatic push(int k, bit h, bit t, logic [3:0] s, logic [3:0] d, logic [15:0] dat);
      flit_t f;
      f.head = h; f.tail = t; f.src = s; f.dest = d; f.data = dat;
      sq[k].push_back(f);
   endtask

   task automatic gen_pkt(int k);
      int len;
      logic [3:0] s, d;
      if ($urandom_range(99) < 6) begin
         push(k, 0, 1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
         return;
      end
      len = $urandom_range(1, 4);
      s = 4'($urandom);
      d = (k == 0 && $urandom_range(1) == 1) ? s : 4'($urandom);
      for (int i = 0; i < len; i++)
         push(k, i == 0, i == len - 1, (i == 0) ? s : 4'($urandom),
              (i == 0) ? d : 4'($urandom), 16'($urandom));
   endtask

   task automatic compare_all();
      int k;
      for (k = 0; k < 2; k++) begin
         logic [31:0] act_port, exp_port, act_cnt, exp_cnt;
         string p;
         p = (k == 0) ? "leaf" : "hub";
         chk({p, "_in_ready"}, 32'(in_ready[k]), 32'((ms[k] == 2) || !mv[k] || out_ready[k]));
         chk({p, "_out_valid"}, 32'(out_valid[k]), 32'(mv[k]));
         chk({p, "_err_drop"}, 32'(err_drop[k]), 32'(med[k]));
         chk({p, "_err_proto"}, 32'(err_proto[k]), 32'(mep[k]));
         act_cnt = (k == 0) ? 32'(cnt_l) : 32'(cnt_h);
         exp_cnt = (k == 0) ? (mcnt[k] % 65536) : (mcnt[k] % 16);
         chk({p, "_pkt_count"}, act_cnt, exp_cnt);
         if (mv[k] || !rst_ni) begin
            act_port = (k == 0) ? 32'(out_port_l) : 32'(out_port_h);
            exp_port = rst_ni ? (32'd1 << midx[k]) : 32'd0;
            chk({p, "_out_port"}, act_port, exp_port);
            chk({p, "_out_idx"}, 32'(out_idx[k]), 32'(midx[k]));
            chk({p, "_out_head"}, 32'(out_head[k]), 32'(mh[k]));
            chk({p, "_out_tail"}, 32'(out_tail[k]), 32'(mt[k]));
            chk({p, "_out_data"}, 32'(out_data[k]), 32'(md[k]));
         end
         if (rst_ni) begin
            log_t e;
            if (out_valid[k] && out_ready[k]) begin
               e.idx = int'(out_idx[k]);
               e.port = (k == 0) ? int'(out_port_l) : int'(out_port_h);
               e.data = out_data[k];
               lg[k].push_back(e);
            end
            if (err_drop[k]) drops_seen[k]++;
            if (err_proto[k]) protos_seen[k]++;
         end
      end
   endtask

   always @(negedge clk) if (chk_en) compare_all();

   initial begin
      int d0, p0;
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 0; in_head[k] = 0; in_tail[k] = 0; in_src[k] = 0;
         in_dest[k] = 0; in_data[k] = 0; out_ready[k] = 1; rdy_force[k] = 1;
         drops_seen[k] = 0; protos_seen[k] = 0;
      end
      model_reset();
      @(posedge clk); #2;
      do_reset();
      chk("lit_reset_cnt_leaf", 32'(cnt_l), 0);

      // leaf, src=3: local then uplink
      push(0, 1, 1, 4'd3, 4'd3, 16'hA001);
      push(0, 1, 1, 4'd3, 4'd5, 16'hA002);
      wait_drain(50);
      chk("lit_leaf_nlog", lg[0].size(), 2);
      if (lg[0].size() == 2) begin
         chk("lit_leaf_port0", lg[0][0].port, 32'b0001);
         chk("lit_leaf_idx0", lg[0][0].idx, 0);
         chk("lit_leaf_port1", lg[0][1].port, 32'b0010);
         chk("lit_leaf_idx1", lg[0][1].idx, 1);
      end
      chk("lit_leaf_cnt", 32'(cnt_l), 2);

      // hub: 4-flit packet to cluster 2, body dests vary
      push(1, 1, 0, 4'd0, 4'b1001, 16'hC000);
      push(1, 0, 0, 4'd0, 4'b0000, 16'hC001);
      push(1, 0, 0, 4'd0, 4'b1111, 16'hC002);
      push(1, 0, 1, 4'd0, 4'b0011, 16'hC003);
      wait_drain(50);
      chk("lit_hub_nlog", lg[1].size(), 4);
      foreach (lg[1][i]) begin
         chk("lit_hub_port", lg[1][i].port, 32'b100);
         chk("lit_hub_idx", lg[1][i].idx, 2);
      end
      chk("lit_hub_cnt1", 32'(cnt_h), 1);

      // hub backpressure mid-packet for 3 cycles
      lg[1].delete();
      for (int i = 0; i < 4; i++) push(1, i == 0, i == 3, 4'd0, 4'b1010, 16'hB000 + 16'(i));
      run_cycles(2);
      rdy_force[1] = 0;
      run_cycles(3);
      rdy_force[1] = 1;
      wait_drain(50);
      chk("lit_bp_nlog", lg[1].size(), 4);
      foreach (lg[1][i]) chk("lit_bp_data", 32'(lg[1][i].data), 32'hB000 + i);
      chk("lit_hub_cnt2", 32'(cnt_h), 2);

      // hub: unroutable cluster 3 packet is dropped
      lg[1].delete();
      d0 = drops_seen[1];
      for (int i = 0; i < 3; i++) push(1, i == 0, i == 2, 4'd0, 4'b1100, 16'hD000 + 16'(i));
      wait_drain(50);
      chk("lit_drop_pulses", drops_seen[1] - d0, 1);
      chk("lit_drop_nlog", lg[1].size(), 0);
      chk("lit_drop_cnt", 32'(cnt_h), 2);

      // hub: headless body flit in idle
      p0 = protos_seen[1];
      push(1, 0, 1, 4'd0, 4'd0, 16'hE000);
      wait_drain(50);
      chk("lit_proto_pulses", protos_seen[1] - p0, 1);
      chk("lit_proto_nlog", lg[1].size(), 0);

      // leaf: reset while a packet is in flight; leftover flits become protocol errors
      p0 = protos_seen[0];
      rdy_force[0] = 0;
      for (int i = 0; i < 3; i++) push(0, i == 0, i == 2, 4'd1, 4'd2, 16'hF000 + 16'(i));
      run_cycles(3);
      chk("lit_fwd_valid_before_rst", 32'(out_valid[0]), 1);
      do_reset();
      rdy_force[0] = 1;
      wait_drain(50);
      chk("lit_rst_proto", protos_seen[0] - p0, 2);

      // hub: counter wraps after 17 packets with a 4-bit count
      do_reset();
      for (int i = 0; i < 17; i++) push(1, 1, 1, 4'd0, 4'd4, 16'(i));
      wait_drain(100);
      chk("lit_wrap_cnt", 32'(cnt_h), 1);

      // randomized traffic with backpressure and occasional mid-stream resets
      rdy_force[0] = -1; rdy_force[1] = -1; vrate = 80;
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 2; k++) if (sq[k].size() < 4) gen_pkt(k);
         if (n % 400 == 399) do_reset();
         else run_cycles(1);
      end
      rdy_force[0] = 1; rdy_force[1] = 1;
      wait_drain(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/star_route_unit.md
# star_route_unit

Parametrised, registered route-compute and flit-forwarding stage for the star NoC, used at both leaf routers and the central hub. It computes the output port for each packet's head flit and holds that route until the tail flit. It forwards flits through one valid/ready register stage, drops packets with unroutable destinations, and counts routed packets. It supersedes the purely combinational leaf route logic.

## Interface
- MODE, 0: 0 = leaf (local vs uplink), 1 = hub (select leaf port from destination cluster field).
- ADDR_W, 4: width of source/destination address.
- LOCAL_W, 2: hub mode only; low address bits local to a leaf; cluster index = dest >> LOCAL_W.
- NUM_PORTS, 5: output ports; leaf mode requires ≥ 2 (port 0 local, port 1 uplink).
- DATA_W, 32: flit payload width.
- CNT_W, 16: packet counter width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input flit accepted when in_valid & in_ready.
- in_head  in  1  flit is packet head.
- in_tail  in  1  flit is packet tail; head & tail = single-flit packet.
- in_src  in  ADDR_W  source address, sampled on head only.
- in_dest  in  ADDR_W  destination address, sampled on head only.
- in_data  in  DATA_W  payload.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_port  out  NUM_PORTS  one-hot selected port.
- out_port_idx  out  $clog2(NUM_PORTS)  binary index of selected port.
- out_head, out_tail  out  1 each  registered copies of in_head/in_tail.
- out_data  out  DATA_W  registered payload.
- err_drop  out  1  one-cycle pulse when an unroutable head is accepted.
- err_proto  out  1  one-cycle pulse when a non-head flit arrives in IDLE.
- pkt_count  out  CNT_W  number of tails forwarded; wraps modulo 2^CNT_W.

## Operation
- Route function on head flits:
  - Leaf mode: in_dest == in_src → idx 0 (local); otherwise idx 1 (uplink).
  - Hub mode: idx = in_dest >> LOCAL_W; idx ≥ NUM_PORTS → unroutable.
- FSM states: IDLE (awaiting head), FWD (route locked), DROP (discarding).
  - IDLE, head accepted, routable: latch idx and forward the flit. Go to FWD, or stay in IDLE if tail is also set.
  - IDLE, head accepted, unroutable: pulse err_drop. Flit is not forwarded. Go to DROP unless tail is also set.
  - IDLE, non-head flit accepted: pulse err_proto, discard the flit, stay in IDLE.
  - FWD: forward each flit on the latched route, ignoring in_dest. A head flit seen here is treated as body. Tail accepted → IDLE.
  - DROP: in_ready = 1, flits are discarded. Tail accepted → IDLE.
- Output stage: in_ready = !out_valid | out_ready (except DROP, where it is 1). Output registers load on accepted forwardable flits. out_valid clears when the flit is consumed and no new flit loads.
- pkt_count increments when a flit with out_tail = 1 is consumed downstream.
- Dropped packets are never counted.

## Timing
- Reset (rst low, asynchronous): out_valid 0, out_port 0, out_port_idx 0, out_head/out_tail 0, out_data 0, err_drop 0, err_proto 0, pkt_count 0, FSM in IDLE, latched route 0.
- Latency: a flit accepted at edge N is presented with out_valid at edge N. out_port is valid in the same cycle as the head flit's out_valid.
- Throughput: 1 flit/cycle with out_ready held high. Backpressure propagates combinationally via in_ready.
- out_* stay stable while out_valid & !out_ready.
- Error pulses are high exactly one cycle, in the cycle after the offending acceptance edge.
- Reset mid-packet: the packet is abandoned and the FSM returns to IDLE. Remaining body flits then trigger err_proto.

## Test plan
- Leaf, src=3: single-flit packet dest=3 → out_port=0001, idx 0, one cycle later; then dest=5 → out_port=0010, idx 1; pkt_count=2.
- Hub, LOCAL_W=2, NUM_PORTS=5: 4-flit packet dest=4'b1001 → idx 2, out_port=00100 on all 4 flits. Changing in_dest on body flits does not alter the route; pkt_count=1.
- Hub, dest=4'b1110 (idx 3) with out_ready low for 3 cycles mid-packet → out_data held stable, no flit loss or duplication, order preserved.
- Hub with NUM_PORTS=3 and dest cluster 3: 3-flit packet → err_drop single pulse, out_valid stays 0, in_ready=1 throughout, FSM back in IDLE, pkt_count unchanged.
- Body flit without a head in IDLE → err_proto pulse, nothing forwarded. rst asserted during FWD → all outputs at reset values immediately.
- CNT_W=4: forward 17 packets → pkt_count wraps to 1.
